// File: rtl/sv_range_monitor_pkg.sv
// Shared types and the window hit rule for sv_range_monitor.
// Bounds are held at a fixed 32-bit width so the package does not depend on DATA_W (DATA_W <= 32).
package sv_range_monitor_pkg;

  localparam int CFG_W = 32;

  typedef struct packed {
    logic [CFG_W-1:0] lo;
    logic [CFG_W-1:0] hi;
    logic             en;
  } range_cfg_t;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    ARMING    = 2'd1,
    ON        = 2'd2,
    RELEASING = 2'd3
  } persist_state_e;

  // lo > hi describes a window that wraps through the top of the range back to 0.
  function automatic logic in_window(range_cfg_t cfg, logic [CFG_W-1:0] d);
    logic hit;
    if (!cfg.en)
      hit = 1'b0;
    else if (cfg.lo <= cfg.hi)
      hit = (d >= cfg.lo) && (d <= cfg.hi);
    else
      hit = (d >= cfg.lo) || (d <= cfg.hi);
    return hit;
  endfunction

endpackage

// File: rtl/sv_range_persist.sv
// Per-window persistence FSM with hysteresis run counter and saturating hit counter.
// Everything advances only when i_adv marks an accepted sample.
module sv_range_persist
  import sv_range_monitor_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PERSIST = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  input  logic             i_hit,
  input  logic             i_cfg_rst,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_cnt,
  output persist_state_e   o_state
);

  localparam int RUN_W = (PERSIST > 1) ? $clog2(PERSIST + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(PERSIST - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  persist_state_e   r_state;
  persist_state_e   w_state_nxt;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    // A config rewrite restarts the filter even if a sample is accepted in the same cycle.
    if (i_cfg_rst) begin
      w_state_nxt = OFF;
      w_run_nxt   = '0;
    end else if (i_adv) begin
      case (r_state)
        OFF: if (i_hit) begin
          if (PERSIST == 1) begin
            w_state_nxt = ON;
            w_run_nxt   = '0;
          end else begin
            w_state_nxt = ARMING;
            w_run_nxt   = RUN_ONE;
          end
        end
        ARMING: if (!i_hit) begin
          w_state_nxt = OFF;
          w_run_nxt   = '0;
        end else if (r_run == RUN_LAST) begin
          w_state_nxt = ON;
          w_run_nxt   = '0;
        end else begin
          w_run_nxt = r_run + RUN_ONE;
        end
        ON: if (!i_hit) begin
          if (PERSIST == 1) begin
            w_state_nxt = OFF;
            w_run_nxt   = '0;
          end else begin
            w_state_nxt = RELEASING;
            w_run_nxt   = RUN_ONE;
          end
        end
        RELEASING: if (i_hit) begin
          w_state_nxt = ON;
          w_run_nxt   = '0;
        end else if (r_run == RUN_LAST) begin
          w_state_nxt = OFF;
          w_run_nxt   = '0;
        end else begin
          w_run_nxt = r_run + RUN_ONE;
        end
        default: begin
          w_state_nxt = OFF;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_cnt_clr)
      r_cnt <= '0;
    else if (i_adv && i_hit && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt   = r_cnt;
  assign o_state = r_state;

endmodule

// File: rtl/sv_range_monitor.sv
// Streaming multi-window range monitor: registered hit flags, filtered alarms, hit counters.
// Handshake: a transfer happens on a side when valid && ready at a rising edge; in_ready = !out_valid || out_ready.
module sv_range_monitor
  import sv_range_monitor_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_RANGES = 4,
  parameter int CNT_W      = 16,
  parameter int PERSIST    = 3,
  localparam int IDX_W     = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [DATA_W-1:0]     cfg_lo,
  input  logic [DATA_W-1:0]     cfg_hi,
  input  logic                  cfg_en,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [NUM_RANGES-1:0] out_hit,
  output logic                  out_any,
  output logic                  out_none,
  output logic [NUM_RANGES-1:0] alarm,
  input  logic [IDX_W-1:0]      cnt_sel,
  output logic [CNT_W-1:0]      cnt_val,
  input  logic                  cnt_clr
);

  range_cfg_t              r_cfg [NUM_RANGES];
  logic                    r_out_valid;
  logic [DATA_W-1:0]       r_out_data;
  logic [NUM_RANGES-1:0]   r_out_hit;
  logic [NUM_RANGES-1:0]   w_hit;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_cnt [NUM_RANGES];
  persist_state_e          w_state [NUM_RANGES];
  logic [CNT_W-1:0]        w_cnt_val;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Hits use the bounds registered before this edge, so a same-cycle write sees old bounds.
  always_comb begin
    for (int i = 0; i < NUM_RANGES; i++)
      w_hit[i] = in_window(r_cfg[i], CFG_W'(in_data));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RANGES; i++)
        r_cfg[i] <= '0;
    end else if (cfg_we && (int'(cfg_idx) < NUM_RANGES)) begin
      r_cfg[cfg_idx] <= '{lo: CFG_W'(cfg_lo), hi: CFG_W'(cfg_hi), en: cfg_en};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_hit   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
      r_out_hit   <= w_hit;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_RANGES; g++) begin : g_win
    sv_range_persist #(
      .CNT_W   (CNT_W),
      .PERSIST (PERSIST)
    ) u_persist (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_adv     (w_accept),
      .i_hit     (w_hit[g]),
      .i_cfg_rst (cfg_we && (int'(cfg_idx) == g)),
      .i_cnt_clr (cnt_clr),
      .o_cnt     (w_cnt[g]),
      .o_state   (w_state[g])
    );
    assign alarm[g] = (w_state[g] == ON) || (w_state[g] == RELEASING);
  end

  always_comb begin
    w_cnt_val = '0;
    for (int i = 0; i < NUM_RANGES; i++)
      if (int'(cnt_sel) == i) w_cnt_val = w_cnt[i];
  end

  assign cnt_val   = w_cnt_val;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_hit   = r_out_hit;
  assign out_any   = |r_out_hit;
  assign out_none  = ~(|r_out_hit);

endmodule
